// File: rtl/clark_transform.sv
// Forward Clarke transform: phase currents (I1,I2,I3) -> alpha/beta (I1 sits on the beta axis).
// Latency: start sampled at edge k, results and done pulse registered at edge k+3.
// Backpressure: none; start edges arriving while busy are dropped.
// Ports: iClk/iRst (sync active-high) clock and reset; iCT_en start request (rising edge);
//        iI1..iI3 signed 16b phase currents; oIalpha/oIbeta signed 16b results;
//        oCT_busy high while a transform is in flight; oCT_done one-cycle completion pulse.
// Build option: CLARK_TWO_SHUNT_EN derives I3 = -(I1+I2) and ignores iI3.
module clark_transform #(
  parameter int unsigned K_INV_SQRT3 = 591,  // 1/sqrt(3) in Q10
  parameter int unsigned K_ONE_THIRD = 341   // 1/3 in Q10
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iCT_en,
  input  logic signed [15:0] iI1,
  input  logic signed [15:0] iI2,
  input  logic signed [15:0] iI3,
  output logic signed [15:0] oIalpha,
  output logic signed [15:0] oIbeta,
  output logic               oCT_busy,
  output logic               oCT_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIFF = 2'd1,
    S_MUL  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic signed [26:0] K_A = 27'(K_INV_SQRT3);
  localparam logic signed [26:0] K_B = 27'(K_ONE_THIRD);

  state_t             state, state_nxt;
  logic               en_prev;
  logic               start;
  logic signed [15:0] i1_q, i1_n, i2_q, i2_n;
  logic signed [16:0] i3_q, i3_n;
  logic signed [17:0] d_q, d_n, s_q, s_n;
  logic signed [26:0] pa_q, pa_n, pb_q, pb_n;
  logic signed [15:0] alpha_n, beta_n;
  logic               done_n;

  // Clamp a (already shifted) product into the 16-bit signed output range.
  function automatic logic signed [15:0] sat16(input logic signed [26:0] v);
    if (v > 27'sd32767)
      return 16'sh7fff;
    else if (v < -27'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  assign start    = iCT_en & ~en_prev;
  assign oCT_busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    i1_n      = i1_q;
    i2_n      = i2_q;
    i3_n      = i3_q;
    d_n       = d_q;
    s_n       = s_q;
    pa_n      = pa_q;
    pb_n      = pb_q;
    alpha_n   = oIalpha;
    beta_n    = oIbeta;
    done_n    = oCT_done;
    case (state)
      S_IDLE: begin
        done_n = 1'b0;
        if (start) begin
          i1_n = iI1;
          i2_n = iI2;
`ifdef CLARK_TWO_SHUNT_EN
          // Only two shunts are sampled; the third current follows from Kirchhoff.
          i3_n = -(17'(iI1) + 17'(iI2));
`else
          i3_n = 17'(iI3);
`endif
          state_nxt = S_DIFF;
        end
      end
      S_DIFF: begin
        d_n       = 18'(i2_q) - 18'(i3_q);
        s_n       = (18'(i1_q) <<< 1) - 18'(i2_q) - 18'(i3_q);
        state_nxt = S_MUL;
      end
      S_MUL: begin
        pa_n      = 27'(d_q) * K_A;
        pb_n      = 27'(s_q) * K_B;
        state_nxt = S_OUT;
      end
      S_OUT: begin
        // Arithmetic shift drops the Q10 fraction with floor rounding.
        alpha_n   = sat16(pa_q >>> 10);
        beta_n    = sat16(pb_q >>> 10);
        done_n    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= S_IDLE;
      en_prev  <= 1'b0;
      i1_q     <= '0;
      i2_q     <= '0;
      i3_q     <= '0;
      d_q      <= '0;
      s_q      <= '0;
      pa_q     <= '0;
      pb_q     <= '0;
      oIalpha  <= '0;
      oIbeta   <= '0;
      oCT_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      en_prev  <= iCT_en;
      i1_q     <= i1_n;
      i2_q     <= i2_n;
      i3_q     <= i3_n;
      d_q      <= d_n;
      s_q      <= s_n;
      pa_q     <= pa_n;
      pb_q     <= pb_n;
      oIalpha  <= alpha_n;
      oIbeta   <= beta_n;
      oCT_done <= done_n;
    end
  end

endmodule
